tick_period_monitor: RTL and testbench
======================================

// Module: tick_period_monitor
// PURPOSE
//  Consumer end of the ms-strobe / period-strobe interface. Counts base ms strobes (ce) between
//  successive period strobes (tick) and reports the measured period. Checks it against the
//  expected period (N ms in test mode, 1000 ms otherwise) and flags early, late or lost ticks.
//  Sits beside the 1 s / N ms strobe generator to self-check its cadence in SPI test builds.
// PARAMETERS
//  N        25  expected period in ms when tmod=1
//  W        11  width of the period counter (must hold 2*1000)
//  TOL      1   allowed +/- deviation in ms before early/late is flagged
//  LOCK_CNT 4   consecutive in-tolerance periods required to assert locked
// PORTS
//  clk      in   1  system clock
//  rst_n    in   1  asynchronous active-low reset
//  ce       in   1  base ms strobe, single-cycle
//  tick     in   1  period strobe under test; normally coincident with ce
//  tmod     in   1  1: expected E=N, 0: expected E=1000
//  period   out  W  last measured period in ms
//  valid    out  1  1-cycle pulse: period/early/late updated
//  early    out  1  last period < E-TOL (held until next valid)
//  late     out  1  last period > E+TOL (held until next valid)
//  lost     out  1  1-cycle pulse: no tick within 2*E ms
//  locked   out  1  LOCK_CNT consecutive in-tolerance periods seen
// BEHAVIOUR
//  - Reset: period=0, valid=0, early=0, late=0, lost=0, locked=0, cnt=0, ok_cnt=0, state=IDLE.
//  - cnt: +1 on each ce without tick. Saturates at 2^W-1. Cleared to 0 on tick.
//  - On tick: meas = cnt + ce. A generator with period N at ce=1 every cycle gives meas=N.
//  - FSM states IDLE, ACQ, LOCK:
//    IDLE: first tick -> ACQ, cnt<=0. No valid pulse; the first partial interval is discarded.
//    ACQ : tick -> period<=meas, valid=1 next cycle, flags updated. In tolerance: ok_cnt+1.
//          Out of tolerance: ok_cnt<=0. At ok_cnt==LOCK_CNT -> LOCK, locked=1.
//    LOCK: tick in tolerance -> stay. Out of tolerance -> ACQ, locked=0, ok_cnt<=0.
//    ACQ/LOCK: when cnt reaches 2*E-1 and ce arrives without tick -> lost=1 for 1 cycle,
//          -> IDLE, locked=0, ok_cnt=0, cnt=0. period is held.
//  - Outputs are registered. valid and lost assert 1 cycle after the causing tick/ce edge.
//  - tmod change (edge detected on registered copy) -> IDLE, locked=0. No valid and no lost.
//  - tick and lost-threshold in the same cycle: tick wins, no lost pulse.
//  - tick with ce=0: accepted, meas=cnt.
//  - Tolerance compare is done in W+1 bits. E-TOL clamps at 0, so no underflow.
//  - Async reset mid-measurement returns to IDLE. The next tick only re-arms; it does not measure.
// CONFIGURATION
//  MON_HIST_EN defined:
//   - Adds port clr (in,1) and ports pmin/pmax (out,W each).
//   - On each valid: pmin<=min(pmin,period), pmax<=max(pmax,period).
//   - clr or reset: pmin=all ones, pmax=0. clr with valid in the same cycle: clr wins.
//  MON_HIST_EN undefined: the ports and registers are absent. All other behaviour is identical.
// TESTING
//  1 tmod=1, ce every cycle, tick every 25 ce -> from 2nd tick valid with period=25, early=late=0; locked after 4th valid.
//  2 locked, then one tick after 20 ce -> period=20, early=1, locked=0; next 25-period -> early=0, ok_cnt restarts.
//  3 ticks stop after lock, ce continues -> lost pulse exactly 50 ce after last tick; state IDLE, locked=0.
//  4 tmod=0, ce every 3 clk, tick every 1000 ce -> period=1000, no flags. Tick at 1002 -> late=1.
//  5 rst_n low mid-interval, then ticks at 25 -> no valid on 1st tick, period=25 on 2nd.
//  6 MON_HIST_EN: periods 25,24,26 -> pmin=24, pmax=26; pulse clr -> pmin=2047, pmax=0.

Source files
------------

// File: rtl/tick_period_monitor.sv
// Measures the ms-strobe count between period ticks, flags early/late/lost ticks and tracks lock.
// Define MON_HIST_EN to add the clr input and pmin/pmax period history outputs.
module tick_period_monitor #(
  parameter int N        = 25,
  parameter int W        = 11,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         tick,
  input  logic         tmod,
`ifdef MON_HIST_EN
  input  logic         clr,
  output logic [W-1:0] pmin,
  output logic [W-1:0] pmax,
`endif
  output logic [W-1:0] period,
  output logic         valid,
  output logic         early,
  output logic         late,
  output logic         lost,
  output logic         locked
);

  localparam int OKW = $clog2(LOCK_CNT + 1);
  localparam logic [W:0] TOL_W = (W+1)'(TOL);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   cnt, cnt_nxt;
  logic [OKW-1:0] ok_cnt, ok_nxt;
  logic           tmod_q;
  logic [W-1:0]   period_nxt;
  logic           valid_nxt, early_nxt, late_nxt, lost_nxt, locked_nxt;
  logic [W:0]     exp_p, lo, hi, meas, lost_thr;
  logic           in_tol, tmod_chg;

  // Compare window is one bit wider than the counter so E+TOL and cnt+ce never wrap.
  always_comb begin
    exp_p    = tmod ? (W+1)'(N) : (W+1)'(1000);
    lo       = (exp_p > TOL_W) ? exp_p - TOL_W : '0;
    hi       = exp_p + TOL_W;
    lost_thr = (exp_p << 1) - (W+1)'(1);
    meas     = {1'b0, cnt} + {{W{1'b0}}, ce};
    in_tol   = (meas >= lo) && (meas <= hi);
    tmod_chg = (tmod != tmod_q);
  end

  // Priority: mode change, then tick, then lost timeout.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = (ce && (cnt != '1)) ? cnt + W'(1) : cnt;
    ok_nxt     = ok_cnt;
    period_nxt = period;
    valid_nxt  = 1'b0;
    early_nxt  = early;
    late_nxt   = late;
    lost_nxt   = 1'b0;
    locked_nxt = locked;
    if (tmod_chg) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      ok_nxt     = '0;
      locked_nxt = 1'b0;
    end else if (tick) begin
      cnt_nxt = '0;
      if (state == IDLE) begin
        state_nxt = ACQ;
      end else begin
        valid_nxt  = 1'b1;
        period_nxt = meas[W] ? '1 : meas[W-1:0];
        early_nxt  = (meas < lo);
        late_nxt   = (meas > hi);
        if (!in_tol) begin
          state_nxt  = ACQ;
          ok_nxt     = '0;
          locked_nxt = 1'b0;
        end else if (state == ACQ) begin
          if (ok_cnt == OKW'(LOCK_CNT - 1)) begin
            state_nxt  = LOCK;
            ok_nxt     = OKW'(LOCK_CNT);
            locked_nxt = 1'b1;
          end else begin
            ok_nxt = ok_cnt + OKW'(1);
          end
        end
      end
    end else if (ce && (state != IDLE) && ({1'b0, cnt} == lost_thr)) begin
      lost_nxt   = 1'b1;
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      ok_nxt     = '0;
      locked_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ok_cnt <= '0;
      tmod_q <= 1'b0;
      period <= '0;
      valid  <= 1'b0;
      early  <= 1'b0;
      late   <= 1'b0;
      lost   <= 1'b0;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ok_cnt <= ok_nxt;
      tmod_q <= tmod;
      period <= period_nxt;
      valid  <= valid_nxt;
      early  <= early_nxt;
      late   <= late_nxt;
      lost   <= lost_nxt;
      locked <= locked_nxt;
    end
  end

`ifdef MON_HIST_EN
  // History folds in the registered period while valid is high; clr overrides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmin <= '1;
      pmax <= '0;
    end else if (clr) begin
      pmin <= '1;
      pmax <= '0;
    end else if (valid) begin
      if (period < pmin) pmin <= period;
      if (period > pmax) pmax <= period;
    end
  end
`endif

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed self-checking bench for tick_period_monitor; covers MON_HIST_EN when defined.
module tb_tick_period_monitor;

  logic        clk = 1'b0;
  logic        rst_n, ce, tick, tmod;
  logic [10:0] period;
  logic        valid, early, late, lost, locked;
`ifdef MON_HIST_EN
  logic        clr;
  logic [10:0] pmin, pmax;
`endif

  int checks = 0;
  int errors = 0;
  int lost_seen = 0;

  tick_period_monitor dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .tick(tick), .tmod(tmod),
`ifdef MON_HIST_EN
    .clr(clr), .pmin(pmin), .pmax(pmax),
`endif
    .period(period), .valid(valid), .early(early), .late(late),
    .lost(lost), .locked(locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (lost) lost_seen <= lost_seen + 1;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle from a negedge; outputs are observable at the following negedge.
  task automatic applyStimulus(input logic c, input logic t);
    ce   = c;
    tick = t;
    @(negedge clk);
    ce   = 1'b0;
    tick = 1'b0;
  endtask

  // n ce strobes spaced gap cycles apart, tick on the last one.
  task automatic sendPeriod(input int n, input int gap);
    for (int i = 1; i <= n; i++) begin
      for (int g = 1; g < gap; g++) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, i == n);
    end
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; tick = 1'b0; tmod = 1'b1;
`ifdef MON_HIST_EN
    clr = 1'b0;
`endif
    @(negedge clk); @(negedge clk);
    checkOutput("rst_period", period, 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_flags", {early, late, lost, locked}, 0);
`ifdef MON_HIST_EN
    checkOutput("rst_pmin", pmin, 2047);
    checkOutput("rst_pmax", pmax, 0);
`endif
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] nominal N-period acquisition and lock");
    sendPeriod(25, 1);
    checkOutput("arm_no_valid", valid, 0);
    for (int k = 1; k <= 4; k++) begin
      sendPeriod(25, 1);
      checkOutput("acq_valid", valid, 1);
      checkOutput("acq_period", period, 25);
      checkOutput("acq_early_late", {early, late}, 0);
      checkOutput("acq_locked", locked, (k == 4) ? 1 : 0);
    end

    $display("[TB] early tick drops lock");
    sendPeriod(20, 1);
    checkOutput("early_period", period, 20);
    checkOutput("early_flag", early, 1);
    checkOutput("early_unlock", locked, 0);
    for (int k = 1; k <= 4; k++) begin
      sendPeriod(25, 1);
      checkOutput("relock_early", early, 0);
      checkOutput("relock_locked", locked, (k == 4) ? 1 : 0);
    end

    $display("[TB] lost tick timeout");
    for (int k = 0; k < 49; k++) applyStimulus(1'b1, 1'b0);
    checkOutput("lost_not_yet", lost, 0);
    checkOutput("lost_none_seen", lost_seen, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("lost_pulse", lost, 1);
    checkOutput("lost_unlock", locked, 0);
    checkOutput("lost_period_held", period, 25);
    applyStimulus(1'b0, 1'b0);
    checkOutput("lost_one_cycle", lost, 0);
    sendPeriod(25, 1);
    checkOutput("lost_rearm_no_valid", valid, 0);
    sendPeriod(25, 1);
    checkOutput("lost_rearm_valid", valid, 1);
    checkOutput("lost_count", lost_seen, 1);

    $display("[TB] tick at lost threshold and tick without ce");
    sendPeriod(50, 1);
    checkOutput("thr_valid", valid, 1);
    checkOutput("thr_no_lost", lost, 0);
    checkOutput("thr_period", period, 50);
    checkOutput("thr_late", late, 1);
    for (int k = 0; k < 25; k++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("noce_valid", valid, 1);
    checkOutput("noce_period", period, 25);
    checkOutput("noce_late", late, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("thr_lost_count", lost_seen, 1);

    $display("[TB] 1000 ms mode");
    tmod = 1'b0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    sendPeriod(1000, 3);
    checkOutput("s_arm_no_valid", valid, 0);
    sendPeriod(1000, 3);
    checkOutput("s_valid", valid, 1);
    checkOutput("s_period", period, 1000);
    checkOutput("s_flags", {early, late}, 0);
    sendPeriod(1001, 3);
    checkOutput("s_1001_period", period, 1001);
    checkOutput("s_1001_late", late, 0);
    sendPeriod(1002, 3);
    checkOutput("s_1002_period", period, 1002);
    checkOutput("s_1002_late", late, 1);

    $display("[TB] async reset mid-interval");
    tmod = 1'b1;
    applyStimulus(1'b0, 1'b0);
    sendPeriod(25, 1);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_period", period, 0);
    checkOutput("arst_late", late, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sendPeriod(25, 1);
    checkOutput("arst_rearm_no_valid", valid, 0);
    sendPeriod(25, 1);
    checkOutput("arst_valid", valid, 1);
    checkOutput("arst_period25", period, 25);

    $display("[TB] tolerance edges and history");
    sendPeriod(24, 1);
    checkOutput("p24_period", period, 24);
    checkOutput("p24_flags", {early, late}, 0);
    sendPeriod(26, 1);
    checkOutput("p26_period", period, 26);
    checkOutput("p26_flags", {early, late}, 0);
    applyStimulus(1'b0, 1'b0);
`ifdef MON_HIST_EN
    checkOutput("hist_pmin", pmin, 24);
    checkOutput("hist_pmax", pmax, 26);
    clr = 1'b1;
    applyStimulus(1'b0, 1'b0);
    clr = 1'b0;
    checkOutput("clr_pmin", pmin, 2047);
    checkOutput("clr_pmax", pmax, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
